// File: rtl/vx_raster_warp_dispatch_if.sv
// Stamp-in / warp-out handshake bundle for the raster warp dispatcher.
//   stamp_valid/stamp_ready/stamp_data : packed raster stamp from the rasterizer
//   warp_valid/warp_ready              : per-warp launch handshake to the scheduler
//   warp_wid/pc/param/cta_*/last       : launch payload, held stable under backpressure
// master: stamp producer + warp consumer; slave: the dispatcher.
interface vx_raster_warp_dispatch_if #(
  parameter int XLEN      = 32,
  parameter int NUM_WARPS = 4
);
  localparam int WID_BITS = $clog2(NUM_WARPS);
  localparam int STAMP_W  = 160 + 2 * XLEN;

  logic                stamp_valid;
  logic [STAMP_W-1:0]  stamp_data;
  logic                stamp_ready;
  logic                warp_valid;
  logic                warp_ready;
  logic [WID_BITS-1:0] warp_wid;
  logic [XLEN-1:0]     warp_pc;
  logic [XLEN-1:0]     warp_param;
  logic [31:0]         warp_cta_x;
  logic [31:0]         warp_cta_y;
  logic [31:0]         warp_cta_z;
  logic [31:0]         warp_cta_id;
  logic                warp_last;

  modport master (
    output stamp_valid, stamp_data, warp_ready,
    input  stamp_ready, warp_valid, warp_wid, warp_pc, warp_param,
           warp_cta_x, warp_cta_y, warp_cta_z, warp_cta_id, warp_last
  );

  modport slave (
    input  stamp_valid, stamp_data, warp_ready,
    output stamp_ready, warp_valid, warp_wid, warp_pc, warp_param,
           warp_cta_x, warp_cta_y, warp_cta_z, warp_cta_id, warp_last
  );
endinterface

// File: rtl/vx_raster_warp_dispatch.sv
// Raster warp dispatcher: accepts one raster stamp, then issues one warp launch
// request per requested warp (clamped to NUM_WARPS), wid 0..N-1.
//   clk, reset  : single clock, asynchronous active-high reset
//   bus         : stamp in / warp launch out handshakes (slave modport)
//   busy        : high while dispatching a stamp
//   clamp_err   : sticky, a stamp asked for more than NUM_WARPS warps
//   stamp_count : number of stamps fully dispatched (wraps)
module vx_raster_warp_dispatch #(
  parameter int XLEN      = 32,
  parameter int NUM_WARPS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  vx_raster_warp_dispatch_if.slave      bus,
  output logic                          busy,
  output logic                          clamp_err,
  output logic [31:0]                   stamp_count
);
  localparam int WID_BITS = $clog2(NUM_WARPS);
  localparam logic [31:0]         MaxWarps32 = 32'(NUM_WARPS);
  localparam logic [WID_BITS:0]   MaxWarpsN  = (WID_BITS + 1)'(NUM_WARPS);

  typedef enum logic [0:0] {StIdle, StDispatch} state_e;

  state_e state_q, state_d;

  // Unpacked stamp fields, MSB first.
  logic [31:0]     s_num, s_x, s_y, s_z, s_id;
  logic [XLEN-1:0] s_pc, s_param;
  assign {s_num, s_pc, s_param, s_x, s_y, s_z, s_id} = bus.stamp_data;

  logic [WID_BITS-1:0] wid_q, wid_d;
  // N is one bit wider than wid so that N == NUM_WARPS is representable.
  logic [WID_BITS:0]   total_q, total_d;
  logic [XLEN-1:0]     pc_q, param_q;
  logic [31:0]         x_q, y_q, z_q, id_q;
  logic                clamp_q, clamp_d;
  logic [31:0]         count_q, count_d;
  logic                hold_load;

  logic stamp_ready, warp_valid, warp_last, stamp_hs, warp_hs;

  // stamp_ready is gated by reset so nothing is accepted until after release.
  assign stamp_ready = (state_q == StIdle) && !reset;
  assign warp_valid  = (state_q == StDispatch);
  assign warp_last   = warp_valid && ({1'b0, wid_q} == (total_q - 1'b1));
  assign stamp_hs    = bus.stamp_valid && stamp_ready;
  assign warp_hs     = warp_valid && bus.warp_ready;

  always_comb begin
    state_d   = state_q;
    wid_d     = wid_q;
    total_d   = total_q;
    clamp_d   = clamp_q;
    count_d   = count_q;
    hold_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (stamp_hs) begin
          hold_load = 1'b1;
          wid_d     = '0;
          // A zero-warp stamp is consumed but dropped.
          if (s_num != 32'd0) begin
            state_d = StDispatch;
            if (s_num > MaxWarps32) begin
              total_d = MaxWarpsN;
              clamp_d = 1'b1;
            end else begin
              total_d = s_num[WID_BITS:0];
            end
          end
        end
      end
      StDispatch: begin
        if (warp_hs) begin
          if (warp_last) begin
            state_d = StIdle;
            count_d = count_q + 32'd1;
          end else begin
            wid_d = wid_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wid_q   <= '0;
      total_q <= '0;
      clamp_q <= 1'b0;
      count_q <= '0;
      pc_q    <= '0;
      param_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      wid_q   <= wid_d;
      total_q <= total_d;
      clamp_q <= clamp_d;
      count_q <= count_d;
      if (hold_load) begin
        pc_q    <= s_pc;
        param_q <= s_param;
        x_q     <= s_x;
        y_q     <= s_y;
        z_q     <= s_z;
        id_q    <= s_id;
      end
    end
  end

  assign bus.stamp_ready = stamp_ready;
  assign bus.warp_valid  = warp_valid;
  assign bus.warp_last   = warp_last;
  assign bus.warp_wid    = wid_q;
  assign bus.warp_pc     = pc_q;
  assign bus.warp_param  = param_q;
  assign bus.warp_cta_x  = x_q;
  assign bus.warp_cta_y  = y_q;
  assign bus.warp_cta_z  = z_q;
  assign bus.warp_cta_id = id_q;

  assign busy        = warp_valid;
  assign clamp_err   = clamp_q;
  assign stamp_count = count_q;
endmodule

// File: tb/tb_vx_raster_warp_dispatch.sv
module tb_vx_raster_warp_dispatch;
  localparam int XLEN = 32;
  localparam int NW   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy, clamp_err;
  logic [31:0] stamp_count;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  vx_raster_warp_dispatch_if #(.XLEN(XLEN), .NUM_WARPS(NW)) bus ();

  vx_raster_warp_dispatch #(.XLEN(XLEN), .NUM_WARPS(NW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .clamp_err   (clamp_err),
    .stamp_count (stamp_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one stamp for a single edge, then scrambles the data bus.
  task automatic send_stamp(input logic [31:0] num, input logic [31:0] pc,
                            input logic [31:0] param, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] z,
                            input logic [31:0] id);
    bus.stamp_data  = {num, pc, param, x, y, z, id};
    bus.stamp_valid = 1'b1;
    step();
    bus.stamp_valid = 1'b0;
    bus.stamp_data  = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom()};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.stamp_valid = 1'b0;
    bus.stamp_data  = '0;
    bus.warp_ready  = 1'b0;
    #3;
    n_cmp++;
    if ({bus.stamp_ready, bus.warp_valid, bus.warp_last, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {bus.stamp_ready, bus.warp_valid, bus.warp_last, busy});
    end
    n_cmp++;
    if ({clamp_err, stamp_count} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_state: got clamp=%b count=%h want 0/0", clamp_err, stamp_count);
    end
    step();
    step();
    #2 reset = 1'b0;
    step();
    n_cmp++;
    if ({bus.stamp_ready, bus.warp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 10", {bus.stamp_ready, bus.warp_valid});
    end
  endtask

  task automatic test_basic();
    bus.warp_ready = 1'b1;
    send_stamp(32'd3, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'd7);
    for (int i = 0; i < 3; i++) begin
      logic [1:0] w;
      w = 2'(i);
      n_cmp++;
      if ({bus.warp_valid, bus.warp_wid, bus.warp_last, busy, bus.stamp_ready} !==
          {1'b1, w, (i == 2), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL basic_warp%0d: got v/wid/last/busy/rdy=%b want %b", i,
                 {bus.warp_valid, bus.warp_wid, bus.warp_last, busy, bus.stamp_ready},
                 {1'b1, w, (i == 2), 1'b1, 1'b0});
      end
      n_cmp++;
      if ({bus.warp_pc, bus.warp_cta_id} !== {32'h8000_0000, 32'd7}) begin
        n_fail++;
        $display("FAIL basic_data%0d: got pc=%h id=%h want 80000000/7", i,
                 bus.warp_pc, bus.warp_cta_id);
      end
      step();
    end
    n_cmp++;
    if ({bus.warp_valid, busy, bus.stamp_ready, stamp_count} !== {3'b001, 32'd1}) begin
      n_fail++;
      $display("FAIL basic_done: got v/busy/rdy=%b count=%0d want 001/1",
               {bus.warp_valid, busy, bus.stamp_ready}, stamp_count);
    end
  endtask

  task automatic test_backpressure();
    bus.warp_ready = 1'b0;
    send_stamp(32'd2, 32'h1000, 32'hABCD, 32'd1, 32'd2, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({bus.warp_valid, bus.warp_wid, bus.warp_last, bus.stamp_ready, bus.warp_pc,
           bus.warp_param, bus.warp_cta_x, bus.warp_cta_y, bus.warp_cta_z, bus.warp_cta_id}
          !== {1'b1, 2'd0, 1'b0, 1'b0, 32'h1000, 32'hABCD, 32'd1, 32'd2, 32'd3, 32'd4}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b wid=%0d last=%b rdy=%b pc=%h param=%h x=%0d y=%0d z=%0d id=%0d want 1/0/0/0/1000/abcd/1/2/3/4",
                 i, bus.warp_valid, bus.warp_wid, bus.warp_last, bus.stamp_ready,
                 bus.warp_pc, bus.warp_param, bus.warp_cta_x, bus.warp_cta_y,
                 bus.warp_cta_z, bus.warp_cta_id);
      end
      step();
    end
    bus.warp_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.warp_valid, bus.warp_wid, bus.warp_last} !== {1'b1, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_wid0: got %b want 1000",
               {bus.warp_valid, bus.warp_wid, bus.warp_last});
    end
    step();
    n_cmp++;
    if ({bus.warp_valid, bus.warp_wid, bus.warp_last, bus.stamp_ready} !==
        {1'b1, 2'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_wid1: got %b want 10110",
               {bus.warp_valid, bus.warp_wid, bus.warp_last, bus.stamp_ready});
    end
    step();
    n_cmp++;
    if ({bus.warp_valid, stamp_count} !== {1'b0, 32'd2}) begin
      n_fail++;
      $display("FAIL bp_done: got v=%b count=%0d want 0/2", bus.warp_valid, stamp_count);
    end
  endtask

  task automatic test_zero();
    bus.warp_ready = 1'b1;
    send_stamp(32'd0, 32'h5555, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({bus.warp_valid, bus.stamp_ready, busy, stamp_count} !== {3'b010, 32'd2}) begin
        n_fail++;
        $display("FAIL zero_drop%0d: got v/rdy/busy=%b count=%0d want 010/2", i,
                 {bus.warp_valid, bus.stamp_ready, busy}, stamp_count);
      end
      step();
    end
    send_stamp(32'd1, 32'h2000, 32'h0, 32'd5, 32'h0, 32'h0, 32'h0);
    n_cmp++;
    if ({bus.warp_valid, bus.warp_wid, bus.warp_last, bus.warp_cta_x, bus.warp_pc} !==
        {1'b1, 2'd0, 1'b1, 32'd5, 32'h2000}) begin
      n_fail++;
      $display("FAIL zero_next: got v=%b wid=%0d last=%b x=%0d pc=%h want 1/0/1/5/2000",
               bus.warp_valid, bus.warp_wid, bus.warp_last, bus.warp_cta_x, bus.warp_pc);
    end
    step();
    n_cmp++;
    if ({bus.warp_valid, stamp_count} !== {1'b0, 32'd3}) begin
      n_fail++;
      $display("FAIL zero_done: got v=%b count=%0d want 0/3", bus.warp_valid, stamp_count);
    end
  endtask

  task automatic test_back_to_back();
    bus.warp_ready  = 1'b1;
    bus.stamp_data  = {32'd1, 32'h3000, 32'h0, 32'h0, 32'h0, 32'h0, 32'd9};
    bus.stamp_valid = 1'b1;
    step();
    n_cmp++;
    if ({bus.warp_valid, bus.warp_last, bus.stamp_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL b2b_first: got %b want 110",
               {bus.warp_valid, bus.warp_last, bus.stamp_ready});
    end
    step();
    // Final warp handshake edge must not also accept the still-offered stamp.
    n_cmp++;
    if ({bus.warp_valid, bus.stamp_ready, stamp_count} !== {2'b01, 32'd4}) begin
      n_fail++;
      $display("FAIL b2b_gap: got v/rdy=%b count=%0d want 01/4",
               {bus.warp_valid, bus.stamp_ready}, stamp_count);
    end
    step();
    n_cmp++;
    if ({bus.warp_valid, bus.warp_cta_id} !== {1'b1, 32'd9}) begin
      n_fail++;
      $display("FAIL b2b_second: got v=%b id=%0d want 1/9", bus.warp_valid, bus.warp_cta_id);
    end
    bus.stamp_valid = 1'b0;
    step();
    n_cmp++;
    if ({bus.warp_valid, stamp_count} !== {1'b0, 32'd5}) begin
      n_fail++;
      $display("FAIL b2b_done: got v=%b count=%0d want 0/5", bus.warp_valid, stamp_count);
    end
  endtask

  task automatic test_clamp();
    bus.warp_ready = 1'b1;
    n_cmp++;
    if (clamp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp_pre: got %b want 0", clamp_err);
    end
    send_stamp(32'd9, 32'h4000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] w;
      w = 2'(i);
      n_cmp++;
      if ({bus.warp_valid, bus.warp_wid, bus.warp_last, clamp_err} !==
          {1'b1, w, (i == 3), 1'b1}) begin
        n_fail++;
        $display("FAIL clamp_warp%0d: got v/wid/last/clamp=%b want %b", i,
                 {bus.warp_valid, bus.warp_wid, bus.warp_last, clamp_err},
                 {1'b1, w, (i == 3), 1'b1});
      end
      step();
    end
    n_cmp++;
    if ({bus.warp_valid, clamp_err, stamp_count} !== {2'b01, 32'd6}) begin
      n_fail++;
      $display("FAIL clamp_done: got v/clamp=%b count=%0d want 01/6",
               {bus.warp_valid, clamp_err}, stamp_count);
    end
    send_stamp(32'd2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    step();
    n_cmp++;
    if ({bus.warp_valid, clamp_err, stamp_count} !== {2'b01, 32'd7}) begin
      n_fail++;
      $display("FAIL clamp_sticky: got v/clamp=%b count=%0d want 01/7",
               {bus.warp_valid, clamp_err}, stamp_count);
    end
  endtask

  task automatic test_reset_mid();
    bus.warp_ready = 1'b1;
    send_stamp(32'd4, 32'h5000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    n_cmp++;
    if ({bus.warp_valid, bus.warp_wid} !== {1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL rmid_pre: got v=%b wid=%0d want 1/1", bus.warp_valid, bus.warp_wid);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.warp_valid, bus.warp_last, busy, bus.stamp_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmid_async: got %b want 0000",
               {bus.warp_valid, bus.warp_last, busy, bus.stamp_ready});
    end
    n_cmp++;
    if ({clamp_err, stamp_count} !== 33'd0) begin
      n_fail++;
      $display("FAIL rmid_clear: got clamp=%b count=%0d want 0/0", clamp_err, stamp_count);
    end
    step();
    #2 reset = 1'b0;
    step();
    n_cmp++;
    if ({bus.warp_valid, bus.stamp_ready, stamp_count} !== {2'b01, 32'd0}) begin
      n_fail++;
      $display("FAIL rmid_idle: got v/rdy=%b count=%0d want 01/0",
               {bus.warp_valid, bus.stamp_ready}, stamp_count);
    end
    send_stamp(32'd2, 32'h6000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    n_cmp++;
    if ({bus.warp_valid, bus.warp_wid, bus.warp_pc} !== {1'b1, 2'd0, 32'h6000}) begin
      n_fail++;
      $display("FAIL rmid_restart: got v=%b wid=%0d pc=%h want 1/0/6000",
               bus.warp_valid, bus.warp_wid, bus.warp_pc);
    end
    step();
    step();
    n_cmp++;
    if ({bus.warp_valid, stamp_count} !== {1'b0, 32'd1}) begin
      n_fail++;
      $display("FAIL rmid_done: got v=%b count=%0d want 0/1", bus.warp_valid, stamp_count);
    end
  endtask

  task automatic test_wrap();
    bus.warp_ready = 1'b1;
    force dut.count_q = 32'hFFFF_FFFF;
    step();
    release dut.count_q;
    #1;
    n_cmp++;
    if (stamp_count !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL wrap_preload: got %h want ffffffff", stamp_count);
    end
    send_stamp(32'd1, 32'h7000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    n_cmp++;
    if ({bus.warp_valid, stamp_count} !== {1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL wrap_count: got v=%b count=%h want 0/00000000",
               bus.warp_valid, stamp_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vx_raster_warp_dispatch.md
VX_RASTER_WARP_DISPATCH -- requirements
Module: VX_raster_warp_dispatch

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of start_pc and param.
REQ-002 SHALL have parameter NUM_WARPS, default 4, power of two ≥2: maximum warps per core; WID_BITS = log2(NUM_WARPS).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 stamp_valid  in  1  raster stamp offered.
REQ-007 stamp_data  in  160+2*XLEN  packed raster stamp, MSB first: num_warps[32], start_pc[XLEN], param[XLEN], cta_x[32], cta_y[32], cta_z[32], cta_id[32].
REQ-008 stamp_ready  out  1  block accepts stamp this cycle.
REQ-009 warp_valid  out  1  warp launch request valid.
REQ-010 warp_ready  in  1  downstream accepts launch.
REQ-011 warp_wid  out  WID_BITS  warp index within stamp.
REQ-012 warp_pc, warp_param  out  XLEN each  captured start_pc, param.
REQ-013 warp_cta_x, warp_cta_y, warp_cta_z, warp_cta_id  out  32 each  captured CTA fields.
REQ-014 warp_last  out  1  current request is final warp of stamp.
REQ-015 busy  out  1  high whenever state is DISPATCH.
REQ-016 clamp_err  out  1  sticky: some stamp requested more than NUM_WARPS warps.
REQ-017 stamp_count  out  32  stamps fully dispatched, wraps 0xFFFFFFFF→0.

Function
REQ-018 SHALL implement FSM with states IDLE and DISPATCH.
REQ-019 IDLE: stamp_ready=1, warp_valid=0; DISPATCH: stamp_ready=0, warp_valid=1.
REQ-020 Stamp handshake (stamp_valid & stamp_ready) SHALL register all stamp fields into a holding register; all warp_* data outputs driven only from that register.
REQ-021 On handshake with num_warps==0: stamp dropped, stay IDLE, stamp_count unchanged, no warp issued.
REQ-022 On handshake with 1≤num_warps≤NUM_WARPS: warp total N=num_warps, wid counter=0, go DISPATCH.
REQ-023 On handshake with num_warps>NUM_WARPS: N=NUM_WARPS, clamp_err set to 1 next edge, go DISPATCH.
REQ-024 Latency: stamp accepted on edge k → warp_valid=1 with warp_wid=0 in cycle after edge k.
REQ-025 Warp handshake (warp_valid & warp_ready) SHALL increment wid counter by 1; warp_wid = counter.
REQ-026 warp_last = (counter == N-1) while in DISPATCH, else 0.
REQ-027 Handshake with warp_last=1: go IDLE, stamp_count += 1 (mod 2^32).
REQ-028 While warp_valid=1 and warp_ready=0, all warp_* outputs SHALL hold stable.
REQ-029 warp_ready asserted with warp_valid=0 SHALL have no effect.
REQ-030 No stamp accepted in same cycle as final warp handshake; minimum one IDLE cycle between stamps.
REQ-031 Fields of stamp_data outside handshake cycles SHALL be ignored.
REQ-032 Counter compare uses N stored as WID_BITS+1 bits so N=NUM_WARPS is representable; counter never wraps.

Reset
REQ-033 Reset assertion SHALL immediately (asynchronously) force state=IDLE, warp_valid=0, warp_last=0, busy=0, stamp_ready=1 after release... held 0 while reset high.
REQ-034 Reset SHALL clear counter, N, holding register, clamp_err, stamp_count to 0.
REQ-035 Reset mid-DISPATCH SHALL abandon the stamp; remaining warps never issued; stamp_count not incremented.
REQ-036 First stamp accepted no earlier than first rising edge after reset deassertion.

Verification
REQ-037 num_warps=3, start_pc=0x80000000, cta_id=7, warp_ready=1 constant -> wid 0,1,2 in three consecutive cycles, warp_last only on wid 2, stamp_count=1, busy 3 cycles.
REQ-038 num_warps=2, warp_ready low 4 cycles then high -> wid 0 outputs stable 4 cycles, then wid 0,1 issued; stamp_ready 0 throughout DISPATCH.
REQ-039 num_warps=0 -> no warp_valid, stamp_count unchanged, stamp_ready stays 1; next stamp num_warps=1 dispatches normally.
REQ-040 num_warps=9 with NUM_WARPS=4 -> exactly 4 warps (wid 0-3), clamp_err=1 and remains 1 after subsequent legal stamps.
REQ-041 reset asserted after wid 1 of a 4-warp stamp -> warp_valid drops same cycle, stamp_count=0, clamp_err=0; new stamp restarts at wid 0.
REQ-042 preload stamp_count to 0xFFFFFFFF via 2^32-1 stamps (or force) then one stamp -> stamp_count=0.
